// File: rtl/rfile_write_arbiter_if.sv
// Write-port bundle: two writeback requesters in, single RFile write port out.
interface rfile_write_arbiter_if #(
  parameter int dataWidth    = 32,
  parameter int AddressWidth = 5
);
  logic                    req0_valid;
  logic [AddressWidth-1:0] req0_addr;
  logic [dataWidth-1:0]    req0_data;
  logic                    req0_ready;
  logic                    req1_valid;
  logic [AddressWidth-1:0] req1_addr;
  logic [dataWidth-1:0]    req1_data;
  logic                    req1_ready;
  logic                    RFwrite;
  logic [AddressWidth-1:0] RegW;
  logic [dataWidth-1:0]    dataW;
  logic                    init_busy;
  logic                    last_grant;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output RFwrite, RegW, dataW, init_busy, last_grant
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  RFwrite, RegW, dataW, init_busy, last_grant
  );
endinterface

// File: rtl/rfile_write_arbiter.sv
// Owns the RFile write port: clears x1..xN after reset, then round-robins
// the ALU (req0) and load-unit (req1) writebacks; x0 writes are absorbed.
module rfile_write_arbiter #(
  parameter int dataWidth    = 32,
  parameter int AddressWidth = 5
) (
  input logic                 Clk,
  input logic                 reset,
  rfile_write_arbiter_if.slave wp
);
  typedef enum logic {Init, Run} state_t;

  state_t                  state, nextState;
  logic [AddressWidth-1:0] initCnt;
  logic                    grant0, grant1;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= Init;
    else        state <= nextState;
  end

  // The counter wraps to zero right after the top register has been issued.
  always_comb begin
    nextState = state;
    if (state == Init && initCnt == '0) nextState = Run;
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == Run) begin
      if (wp.req0_valid && (!wp.req1_valid || wp.last_grant)) grant0 = 1'b1;
      else if (wp.req1_valid)                                 grant1 = 1'b1;
    end
  end

  assign wp.req0_ready = grant0;
  assign wp.req1_ready = grant1;
  assign wp.init_busy  = (state == Init);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      initCnt       <= AddressWidth'(1);
      wp.RFwrite    <= 1'b0;
      wp.RegW       <= '0;
      wp.dataW      <= '0;
      wp.last_grant <= 1'b1;
    end else if (state == Init) begin
      if (initCnt != '0) begin
        wp.RFwrite <= 1'b1;
        wp.RegW    <= initCnt;
        wp.dataW   <= '0;
        initCnt    <= initCnt + AddressWidth'(1);
      end else begin
        wp.RFwrite <= 1'b0;
      end
    end else if (grant0) begin
      wp.last_grant <= 1'b0;
      wp.RegW       <= wp.req0_addr;
      wp.dataW      <= wp.req0_data;
      wp.RFwrite    <= |wp.req0_addr;
    end else if (grant1) begin
      wp.last_grant <= 1'b1;
      wp.RegW       <= wp.req1_addr;
      wp.dataW      <= wp.req1_data;
      wp.RFwrite    <= |wp.req1_addr;
    end else begin
      wp.RFwrite <= 1'b0;
    end
  end
endmodule

// File: doc/rfile_write_arbiter.md
Name: rfile_write_arbiter

Overview:
- Owns the single write port (RFwrite/RegW/dataW) of the RFile register file in the RISC-V core.
- After reset, sequences a clear of registers 1..2^AddressWidth-1 to zero.
- In normal operation, shares the write port round-robin between two writeback requesters (req0 = ALU writeback, req1 = load-unit writeback) using valid/ready handshakes.
- Register x0 writes are absorbed, never issued.

Parameters:
- dataWidth, 32: width of write data.
- AddressWidth, 5: register address width; the register file holds 2^AddressWidth registers.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req0_valid  input  1  requester 0 holds a write.
- req0_addr  input  AddressWidth  requester 0 destination register.
- req0_data  input  dataWidth  requester 0 write data.
- req0_ready  output  1  arbiter accepts requester 0 this cycle.
- req1_valid  input  1  requester 1 holds a write.
- req1_addr  input  AddressWidth  requester 1 destination register.
- req1_data  input  dataWidth  requester 1 write data.
- req1_ready  output  1  arbiter accepts requester 1 this cycle.
- RFwrite  output  1  write enable to RFile.
- RegW  output  AddressWidth  write address to RFile.
- dataW  output  dataWidth  write data to RFile.
- init_busy  output  1  clear sequence in progress.
- last_grant  output  1  index of the most recently granted requester.

Behaviour:
- Reset (reset=0, asynchronous): state=INIT, init counter=1, RFwrite=0, RegW=0, dataW=0, init_busy=1, last_grant=1 (so req0 wins the first tie), req0_ready=req1_ready=0.
- Write-port outputs are registered. A handshake in cycle N produces RFwrite=1 with RegW/dataW valid in cycle N+1, and RFile captures it at the edge ending N+1.
- INIT state:
  - Each rising edge drives RFwrite=1, RegW=counter, dataW=0, then increments counter.
  - Writes registers 1..2^AddressWidth-1 on consecutive cycles (31 cycles at default).
  - On the edge after RegW=2^AddressWidth-1 has been presented: state=RUN, init_busy=0, RFwrite=0.
  - Both ready outputs stay 0 throughout INIT; valids are ignored.
- RUN state, ready outputs are combinational from valids and last_grant:
  - Only req0_valid=1: req0_ready=1.
  - Only req1_valid=1: req1_ready=1.
  - Both valid: the requester not equal to last_grant gets ready=1; the other gets 0.
  - Neither valid: both ready=0.
  - At most one ready is ever high.
- Handshake: valid&ready at a rising edge.
  - On handshake: last_grant<=winner index; RegW<=addr; dataW<=data.
  - RFwrite<=1 only if addr!=0. For addr=0 the handshake completes, RFwrite<=0, and the pointer still advances.
- No handshake in a cycle: RFwrite<=0. RegW and dataW hold their previous values.
- A requester keeps valid/addr/data stable until it sees ready. The arbiter does not buffer, so the loser of a tie stalls one cycle.
- Back-to-back: sustained requests from both sides alternate grants every cycle (0,1,0,1...), one write per cycle, no bubbles.
- Reset asserted mid-INIT or mid-RUN: immediately returns to the reset values above, and the clear sequence restarts from register 1 after release. Any in-flight write presented on the outputs is dropped (RFwrite forced to 0).
- Reset deasserted while valids are high: no grant until INIT completes.

Test Plan:
- Release reset, hold both valids low -> RFwrite=1 for exactly 31 cycles with RegW=1..31 and dataW=0; init_busy falls the next cycle; RFile reads of x5 and x31 return 0.
- After INIT, req0_valid=1, addr=3, data=32'h00000003 for one cycle -> req0_ready=1 same cycle; next cycle RFwrite=1, RegW=3, dataW=32'h3; RFile dataA with RegA=3 reads 3 thereafter.
- Both valid continuously (req0 addr=1 data=32'hA, req1 addr=2 data=32'hB) -> grants alternate 0,1,0,1; RegW sequence 1,2,1,2 on consecutive cycles; never both ready.
- req1_valid=1, addr=0, data=32'hFFFFFFFF -> req1_ready=1, handshake completes, RFwrite stays 0, last_grant=1; reading x0 returns 0.
- Assert reset (0) at INIT cycle 10, release after 2 cycles -> outputs reset asynchronously; clear restarts at RegW=1; total 31 clear writes after release.
- Hold req0_valid=1 during INIT -> req0_ready=0 for all of INIT; granted in the first RUN cycle.
